// File: rtl/gray_seq_ctrl_pkg.sv
// Shared constants and state encoding for the Gray-code sequence controller.
package gray_seq_ctrl_pkg;

  // Default code width in bits.
  localparam int unsigned DefaultW = 3;

  // Controller states; the encodings are visible on a debug bus and must stay fixed.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/gray_seq_ctrl_binary_to_gray.sv
// Binary to reflected-Gray converter, W bits wide, purely combinational.
module gray_seq_ctrl_binary_to_gray #(
  parameter int unsigned W = 3
) (
  input  logic [W-1:0] bin_i,
  output logic [W-1:0] gray_o
);

  // Each Gray bit is the XOR of a binary bit and its more-significant neighbour.
  always_comb begin
    gray_o = bin_i ^ (bin_i >> 1);
  end

endmodule

// File: rtl/gray_seq_ctrl.sv
// Sequence controller: emits a run of binary/Gray code pairs with valid/ready handshake.
module gray_seq_ctrl
  import gray_seq_ctrl_pkg::*;
#(
  parameter int unsigned W = DefaultW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         dir,
  input  logic [W-1:0] base,
  input  logic [W-1:0] len_m1,
  input  logic         stop,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] b_out,
  output logic [W-1:0] g_out,
  output logic         busy,
  output logic         done
);

  localparam logic [W-1:0] One = {{(W-1){1'b0}}, 1'b1};

  state_e       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] rem_q, rem_d;
  logic         dir_q, dir_d;

  logic         beat;
  logic [W-1:0] cnt_step;

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
    end
  end

  // Next-state and datapath update; W-bit arithmetic gives the modulo-2^W wrap.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dir_d    = dir_q;
    beat     = (state_q == StRun) && ready;
    cnt_step = dir_q ? (cnt_q - One) : (cnt_q + One);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          dir_d   = dir;
          cnt_d   = base;
          rem_d   = len_m1;
          state_d = StRun;
        end
      end
      StRun: begin
        // A beat accepted together with stop still advances, but stop wins the state.
        if (beat && (rem_q != '0)) begin
          cnt_d = cnt_step;
          rem_d = rem_q - One;
        end
        if (stop) begin
          state_d = StIdle;
        end else if (beat && (rem_q == '0)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Handshake and status outputs decoded from the state register.
  always_comb begin
    valid = (state_q == StRun);
    busy  = (state_q == StRun);
    done  = (state_q == StDone);
    b_out = cnt_q;
  end

  gray_seq_ctrl_binary_to_gray #(
    .W (W)
  ) u_b2g (
    .bin_i  (cnt_q),
    .gray_o (g_out)
  );

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Scoreboard bench for gray_seq_ctrl: expected codes queued at start, popped on accepted beats.
module tb_gray_seq_ctrl;

  localparam int unsigned W = 3;

  typedef struct {
    logic [W-1:0] b;
    logic [W-1:0] g;
  } code_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic         dir;
  logic [W-1:0] base;
  logic [W-1:0] len_m1;
  logic         stop;
  logic         ready;
  logic         valid;
  logic [W-1:0] b_out;
  logic [W-1:0] g_out;
  logic         busy;
  logic         done;

  code_t sb_q[$];
  int    n_checks;
  int    n_errors;
  int    done_cnt;

  gray_seq_ctrl #(
    .W (W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .dir    (dir),
    .base   (base),
    .len_m1 (len_m1),
    .stop   (stop),
    .ready  (ready),
    .valid  (valid),
    .b_out  (b_out),
    .g_out  (g_out),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Monitor: compare every accepted beat against the scoreboard; count done pulses.
  always @(negedge clk) begin
    code_t e;
    if (done) begin
      done_cnt++;
      check_eq("done_valid", 32'(valid), 32'd0);
    end
    if (!rst && valid && ready) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        check_eq("b_out", 32'(b_out), 32'(e.b));
        check_eq("g_out", 32'(g_out), 32'(e.g));
      end
    end
  end

  // Accept a start and queue the expected code stream.
  task automatic launch(input logic d, input logic [W-1:0] b0, input logic [W-1:0] lm1,
                        input bit use_table);
    logic [W-1:0] g_tab [8];
    logic [W-1:0] b;
    code_t        e;
    g_tab = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
    @(posedge clk);
    #1;
    start  = 1'b1;
    dir    = d;
    base   = b0;
    len_m1 = lm1;
    b      = b0;
    for (int i = 0; i <= int'(lm1); i++) begin
      e.b = b;
      e.g = use_table ? g_tab[i] : to_gray(b);
      sb_q.push_back(e);
      b = d ? (b - 3'd1) : (b + 3'd1);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Complete sequence: drain the scoreboard, then expect exactly one done pulse.
  task automatic run_seq(input logic d, input logic [W-1:0] b0, input logic [W-1:0] lm1,
                         input bit use_table);
    int done0;
    done0 = done_cnt;
    launch(d, b0, lm1, use_table);
    for (int i = 0; i < 64 && sb_q.size() != 0; i++) @(posedge clk);
    check_eq("drain", 32'(sb_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("done_once", 32'(done_cnt - done0), 32'd1);
    check_eq("idle_busy", 32'(busy), 32'd0);
  endtask

  // Abort a sequence with stop on code index idx; no done may follow.
  task automatic run_stop(input logic [W-1:0] b0, input logic [W-1:0] lm1, input int idx);
    int done0;
    done0 = done_cnt;
    launch(1'b0, b0, lm1, 1'b0);
    repeat (idx) begin
      @(posedge clk);
      #1;
    end
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    check_eq("stop_sb_pending", 32'(sb_q.size()), 32'(int'(lm1) - idx));
    sb_q.delete();
    @(negedge clk);
    check_eq("stop_busy", 32'(busy), 32'd0);
    check_eq("stop_valid", 32'(valid), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("stop_no_done", 32'(done_cnt - done0), 32'd0);
  endtask

  initial begin
    int done0;
    n_checks = 0;
    n_errors = 0;
    done_cnt = 0;
    rst      = 1'b1;
    start    = 1'b0;
    dir      = 1'b0;
    base     = '0;
    len_m1   = '0;
    stop     = 1'b0;
    ready    = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", 32'(valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_b", 32'(b_out), 32'd0);
    check_eq("rst_g", 32'(g_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Full up-count, Gray values against a literal table
    run_seq(1'b0, 3'd0, 3'd7, 1'b1);
    // Up with wrap, down with wrap
    run_seq(1'b0, 3'd6, 3'd3, 1'b0);
    run_seq(1'b1, 3'd1, 3'd2, 1'b0);
    // Single-code sequence
    run_seq(1'b1, 3'd5, 3'd0, 1'b0);

    // Backpressure on b_out=2, plus start ignored in RUN and DONE
    done0 = done_cnt;
    launch(1'b0, 3'd0, 3'd4, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    ready  = 1'b0;
    start  = 1'b1;
    base   = 3'd5;
    len_m1 = 3'd1;
    repeat (3) begin
      @(negedge clk);
      check_eq("stall_b", 32'(b_out), 32'd2);
      check_eq("stall_g", 32'(g_out), 32'b011);
      check_eq("stall_valid", 32'(valid), 32'd1);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check_eq("start_in_done_valid", 32'(valid), 32'd0);
    @(negedge clk);
    check_eq("start_in_done_busy", 32'(busy), 32'd0);
    check_eq("stall_drain", 32'(sb_q.size()), 32'd0);
    check_eq("stall_done_once", 32'(done_cnt - done0), 32'd1);

    // Stop on the 3rd code of 8, then a fresh start is accepted
    run_stop(3'd0, 3'd7, 2);
    run_seq(1'b0, 3'd3, 3'd2, 1'b0);
    // Stop coinciding with the last (only) code: stop wins, no done
    run_stop(3'd4, 3'd0, 0);
    run_seq(1'b1, 3'd0, 3'd1, 1'b0);

    // Asynchronous reset between edges mid-RUN
    done0 = done_cnt;
    launch(1'b0, 3'd3, 3'd7, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_eq("arst_valid", 32'(valid), 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_done", 32'(done), 32'd0);
    check_eq("arst_b", 32'(b_out), 32'd0);
    check_eq("arst_g", 32'(g_out), 32'd0);
    sb_q.delete();
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("post_rst_valid", 32'(valid), 32'd0);
    check_eq("post_rst_no_done", 32'(done_cnt - done0), 32'd0);
    run_seq(1'b0, 3'd7, 3'd1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
